// File: rtl/clk_ratio_monitor.sv
// Passive divided-clock checker: measures period and high time in reference cycles,
// scores each period against the programmed ratio, and reports lock and stuck status.
module clk_ratio_monitor #(
  parameter int RATIO_WIDTH = 5,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_mon_en,
  input  logic                   i_div_clk,
  input  logic [RATIO_WIDTH-1:0] i_exp_ratio,
  output logic [RATIO_WIDTH:0]   o_meas_period,
  output logic [RATIO_WIDTH:0]   o_meas_high,
  output logic                   o_meas_valid,
  output logic                   o_ratio_err,
  output logic                   o_locked,
  output logic                   o_stuck
);

  localparam int CW = RATIO_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_PRE  = CNT_MAX - CNT_ONE;
  localparam logic [3:0]    LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0]    LOCK_PRE = LOCK_N - 4'd1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;

  state_t                 state;
  logic                   s1;
  logic                   s2;
  logic [RATIO_WIDTH-1:0] exp_q;
  logic [CW-1:0]          period_cnt;
  logic [CW-1:0]          high_cnt;
  logic [CW-1:0]          idle_cnt;
  logic [3:0]             match_cnt;

  logic rise;
  logic run_ok;
  logic ratio_chg;
  logic stuck_hit;
  logic period_match;

  assign rise         = s1 & ~s2;
  assign run_ok       = i_mon_en & (|i_exp_ratio[RATIO_WIDTH-1:1]);
  assign ratio_chg    = (i_exp_ratio != exp_q);
  assign stuck_hit    = ~rise & (idle_cnt == CNT_PRE);
  assign period_match = (period_cnt == {1'b0, i_exp_ratio});

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      exp_q         <= '0;
      period_cnt    <= '0;
      high_cnt      <= '0;
      idle_cnt      <= '0;
      match_cnt     <= '0;
      o_meas_period <= '0;
      o_meas_high   <= '0;
      o_meas_valid  <= 1'b0;
      o_ratio_err   <= 1'b0;
      o_locked      <= 1'b0;
      o_stuck       <= 1'b0;
    end else begin
      s1           <= i_div_clk;
      s2           <= s1;
      exp_q        <= i_exp_ratio;
      o_meas_valid <= 1'b0;
      o_ratio_err  <= 1'b0;

      if (!run_ok) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
        idle_cnt   <= '0;
        match_cnt  <= '0;
        o_locked   <= 1'b0;
        o_stuck    <= 1'b0;
      end else if (state == IDLE) begin
        state <= ACQUIRE;
      end else begin
        // Idle counter saturates so the stuck event fires exactly once per outage.
        if (rise) begin
          idle_cnt <= '0;
          o_stuck  <= 1'b0;
        end else if (idle_cnt != CNT_MAX) begin
          idle_cnt <= idle_cnt + CNT_ONE;
        end
        if (stuck_hit) begin
          o_stuck <= 1'b1;
        end

        // A ratio change or an outage discards the period in flight.
        if (ratio_chg || stuck_hit) begin
          state      <= ACQUIRE;
          period_cnt <= CNT_ONE;
          high_cnt   <= CNT_ONE;
          match_cnt  <= '0;
          o_locked   <= 1'b0;
        end else if (state == ACQUIRE) begin
          if (rise) begin
            state      <= MEASURE;
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
          end
        end else if (rise) begin
          o_meas_period <= period_cnt;
          o_meas_high   <= high_cnt;
          o_meas_valid  <= 1'b1;
          period_cnt    <= CNT_ONE;
          high_cnt      <= CNT_ONE;
          if (period_match) begin
            if (match_cnt < LOCK_N) begin
              match_cnt <= match_cnt + 4'd1;
            end
            if (match_cnt >= LOCK_PRE) begin
              o_locked <= 1'b1;
            end
          end else begin
            o_ratio_err <= 1'b1;
            match_cnt   <= '0;
            o_locked    <= 1'b0;
          end
        end else begin
          period_cnt <= period_cnt + CNT_ONE;
          if (s1) begin
            high_cnt <= high_cnt + CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized ratio/enable/outage segments.
module tb_clk_ratio_monitor;

  logic       clk;
  logic       rst;
  logic       mon_en;
  logic       div_clk;
  logic [4:0] exp_ratio;
  logic [5:0] meas_period;
  logic [5:0] meas_high;
  logic       meas_valid;
  logic       ratio_err;
  logic       locked;
  logic       stuck;

  clk_ratio_monitor #(.RATIO_WIDTH(5), .LOCK_COUNT(4)) dut (
    .i_ref_clk     (clk),
    .i_rst         (rst),
    .i_mon_en      (mon_en),
    .i_div_clk     (div_clk),
    .i_exp_ratio   (exp_ratio),
    .o_meas_period (meas_period),
    .o_meas_high   (meas_high),
    .o_meas_valid  (meas_valid),
    .o_ratio_err   (ratio_err),
    .o_locked      (locked),
    .o_stuck       (stuck)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Divider stand-in, driven on the falling edge
  int div_ratio = 2;
  bit div_stop  = 0;
  int phase     = 0;

  // Reference model state (timestamps rather than counters)
  int m_mode = 0;  // 0 idle, 1 acquire, 2 measure
  bit d1 = 0, d2 = 0;
  int m_last = 0, m_pstart = 0, m_hc = 0, m_streak = 0, m_exp_prev = 0;
  int m_period = 0, m_high = 0;
  bit m_valid = 0, m_err = 0, m_locked = 0, m_stuck = 0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, expv, expv, cyc);
    end
  endtask

  function automatic int pack(input int p, input int h, input bit v, input bit e, input bit l, input bit s);
    return (p << 10) | (h << 4) | (int'(v) << 3) | (int'(e) << 2) | (int'(l) << 1) | int'(s);
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    div_clk = 0;
    forever begin
      @(negedge clk);
      if (div_stop) begin
        div_clk = 0;
        phase = div_ratio - 1;
      end else if (div_ratio < 2) begin
        div_clk = ~div_clk;
      end else begin
        if (phase >= div_ratio - 1) phase = 0;
        else phase++;
        div_clk = (phase < div_ratio / 2);
      end
    end
  end

  // Model update on every rising edge, then compare every output 1 time unit later.
  initial begin
    forever begin
      bit rise, hit;
      int e;
      @(posedge clk);
      cyc++;
      e = int'(exp_ratio);
      if (rst) begin
        m_mode = 0; d1 = 0; d2 = 0; m_last = 0; m_pstart = 0; m_hc = 0;
        m_streak = 0; m_exp_prev = 0; m_period = 0; m_high = 0;
        m_valid = 0; m_err = 0; m_locked = 0; m_stuck = 0;
      end else begin
        rise = d1 && !d2;
        m_valid = 0;
        m_err = 0;
        if (!mon_en || e < 2) begin
          m_mode = 0; m_locked = 0; m_stuck = 0; m_streak = 0;
        end else if (m_mode == 0) begin
          m_mode = 1;
          m_last = cyc;
        end else begin
          hit = !rise && (cyc - m_last == 63);
          if (rise) begin
            m_last = cyc;
            m_stuck = 0;
          end
          if (hit) m_stuck = 1;
          if (e != m_exp_prev || hit) begin
            m_mode = 1; m_streak = 0; m_locked = 0;
          end else if (m_mode == 1) begin
            if (rise) begin
              m_mode = 2; m_pstart = cyc; m_hc = 1;
            end
          end else if (rise) begin
            m_valid = 1;
            m_period = cyc - m_pstart;
            m_high = m_hc;
            m_pstart = cyc;
            m_hc = 1;
            if (m_period == e) begin
              if (m_streak < 4) m_streak++;
              if (m_streak == 4) m_locked = 1;
            end else begin
              m_err = 1; m_streak = 0; m_locked = 0;
            end
          end else begin
            m_hc += int'(d1);
          end
        end
        m_exp_prev = e;
        d2 = d1;
        d1 = div_clk;
      end
      #1;
      chk("cycle_outputs", pack(int'(meas_period), int'(meas_high), meas_valid, ratio_err, locked, stuck),
          pack(m_period, m_high, m_valid, m_err, m_locked, m_stuck));
    end
  end

  task automatic wait_valid(output int vc);
    vc = -1000;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (meas_valid) begin
        vc = cyc;
        return;
      end
    end
    chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int vc, prev, nv, acc, rel;
    bit found;
    rst = 1; mon_en = 0; exp_ratio = 0;
    @(posedge clk);
    #1;
    chk("reset_outputs", pack(int'(meas_period), int'(meas_high), meas_valid, ratio_err, locked, stuck), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Ratio 2: valid every 2 cycles, lock on the 4th
    @(negedge clk);
    mon_en = 1; exp_ratio = 2; div_ratio = 2;
    prev = 0;
    for (int i = 1; i <= 6; i++) begin
      wait_valid(vc);
      chk("r2_period", int'(meas_period), 2);
      chk("r2_high", int'(meas_high), 1);
      if (i > 1) chk("r2_spacing", vc - prev, 2);
      if (i == 3) chk("r2_not_locked_3rd", int'(locked), 0);
      if (i == 4) chk("r2_locked_4th", int'(locked), 1);
      prev = vc;
    end

    // Ratio 8, then switch both sides to 3
    @(negedge clk);
    exp_ratio = 8; div_ratio = 8;
    for (int i = 1; i <= 5; i++) begin
      wait_valid(vc);
      chk("r8_period", int'(meas_period), 8);
      chk("r8_high", int'(meas_high), 4);
      if (i > 1) chk("r8_spacing", vc - prev, 8);
      if (i == 4) chk("r8_locked_4th", int'(locked), 1);
      prev = vc;
    end
    chk("model_r8_period", m_period, 8);
    chk("model_r8_high", m_high, 4);
    @(negedge clk);
    exp_ratio = 3; div_ratio = 3;
    @(posedge clk);
    #1;
    chk("chg_unlock", int'(locked), 0);
    chk("chg_no_err", int'(ratio_err), 0);
    for (int i = 1; i <= 5; i++) begin
      wait_valid(vc);
      chk("r3_period", int'(meas_period), 3);
      chk("r3_high", int'(meas_high), 1);
      if (i == 3) chk("r3_not_locked_3rd", int'(locked), 0);
      if (i == 4) chk("r3_locked_4th", int'(locked), 1);
    end

    // Expected 5, divider at 4: every valid is an error
    @(negedge clk);
    exp_ratio = 5; div_ratio = 4;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(vc);
      chk("mis_period", int'(meas_period), 4);
      chk("mis_err", int'(ratio_err), 1);
      chk("mis_unlocked", int'(locked), 0);
    end

    // Ratio 7 lock, then hold the divided clock low
    @(negedge clk);
    exp_ratio = 7; div_ratio = 7;
    for (int i = 1; i <= 5; i++) wait_valid(vc);
    chk("r7_locked", int'(locked), 1);
    chk("r7_high", int'(meas_high), 3);
    @(negedge clk);
    div_stop = 1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (stuck) found = 1;
    end
    chk("stuck_delay", cyc - vc, 63);
    chk("stuck_unlocked", int'(locked), 0);
    @(negedge clk);
    div_stop = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (!stuck) found = 1;
    end
    chk("stuck_cleared", int'(stuck), 0);
    chk("stuck_clear_no_valid", int'(meas_valid), 0);
    for (int i = 1; i <= 4; i++) begin
      wait_valid(vc);
      chk("relock_period", int'(meas_period), 7);
      if (i == 3) chk("relock_not_3rd", int'(locked), 0);
      if (i == 4) chk("relock_4th", int'(locked), 1);
    end

    // Bypass ratio, then monitor disabled
    @(negedge clk);
    exp_ratio = 1; div_ratio = 1;
    nv = 0; acc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      nv += int'(meas_valid);
      acc += int'(ratio_err) + int'(locked) + int'(stuck);
    end
    chk("bypass_valids", nv, 0);
    chk("bypass_status", acc, 0);
    @(negedge clk);
    mon_en = 0; exp_ratio = 4; div_ratio = 4;
    nv = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      nv += int'(meas_valid);
    end
    chk("disabled_valids", nv, 0);

    // Asynchronous reset in the middle of a measured period
    @(negedge clk);
    mon_en = 1;
    wait_valid(vc);
    wait_valid(vc);
    chk("pre_rst_period", int'(meas_period), 4);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("async_rst_outputs", pack(int'(meas_period), int'(meas_high), meas_valid, ratio_err, locked, stuck), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    rel = cyc;
    wait_valid(vc);
    chk("post_rst_period", int'(meas_period), 4);
    chk("post_rst_full_period", int'((vc - rel) >= 4), 1);

    // Randomized segments: enable, ratios, mismatches and outages
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      mon_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) exp_ratio = 5'($urandom_range(0, 1));
      else exp_ratio = 5'($urandom_range(2, 20));
      if ($urandom_range(0, 3) == 0) div_ratio = int'($urandom_range(2, 20));
      else div_ratio = (int'(exp_ratio) < 2) ? 2 : int'(exp_ratio);
      div_stop = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(10, 120)) @(posedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
